// File: rtl/krypton_pkg.sv
// Shared types and constants for the scanline display path.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
//
// Contents: visible/total raster timing, the framebuffer address width, the
// RGB565 pixel type, the line-fetch FSM state type, and a helper that turns a
// line number into its framebuffer word offset with shift/add terms only.
package krypton_pkg;

  // Raster timing (pixels / lines)
  localparam int H_VISIBLE = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_TOTAL   = 525;

  // Framebuffer word address width and pixel width
  localparam int FB_AW = 19;
  localparam int PIX_W = 16;

  // Display column index width and per-bank count width (count may equal 1024)
  localparam int X_W   = 10;
  localparam int CNT_W = 11;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  // y * h as a sum of shifted copies of y, one term per set bit of h.
  // With h constant this collapses to a fixed adder tree (640 -> y<<9 + y<<7).
  // Result wraps at FB_AW bits.
  function automatic logic [FB_AW-1:0] line_offset(input logic [8:0] y,
                                                   input int unsigned h);
    logic [FB_AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < FB_AW; i++) begin
      if (h[i]) begin
        acc = acc + (FB_AW'(y) << i);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One scanline bank: simple dual-port RAM, one write port, one read port.
// Latency: 1 cycle, read data registered on the edge that samples re/raddr.
// Backpressure: none; both ports accept an access every cycle.
//
// Ports:
//   clk          rising-edge clock
//   we/waddr/wdata  write strobe, column, pixel
//   re/raddr     read strobe, column; rdata holds its value while re is low
//   rdata        registered read pixel
// Contents are never reset; the owner tracks which entries are meaningful.
module line_ram
  import krypton_pkg::*;
#(
  parameter int DEPTH = H_VISIBLE,
  parameter int AW    = X_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rgb565_t       wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output rgb565_t       rdata
);

  rgb565_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/scanline_buffer.sv
// Double-buffered scanline store: fetches one framebuffer line into the back bank while the display reads the other.
// Latency: rd_en -> pix_rgb 1 cycle; fetch issues one word request per cycle at best (one outstanding).
// Backpressure: mem_req/mem_addr held until mem_ack; display side has none (late fetch flagged as underrun).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   fetch_start, fetch_y start fetching line fetch_y into the back bank
//   swap                 start of visible line: back bank becomes display bank
//   rd_en, rd_x          display read strobe and column
//   pix_rgb              RGB565 pixel, 0 when not reading or beyond fetched data
//   mem_req, mem_addr    framebuffer word request
//   mem_ack, mem_rdata   request accepted, read data in the same cycle
//   underrun             sticky: a swap caught the back bank still filling
module scanline_buffer
  import krypton_pkg::*;
#(
  parameter int               H_PIXELS = H_VISIBLE,
  parameter logic [FB_AW-1:0] FB_BASE  = 19'h00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_start,
  input  logic [8:0]       fetch_y,
  input  logic             swap,
  input  logic             rd_en,
  input  logic [X_W-1:0]   rd_x,
  output logic [PIX_W-1:0] pix_rgb,
  output logic             mem_req,
  output logic [FB_AW-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic             underrun
);

  localparam logic [CNT_W-1:0] H_CNT = CNT_W'(H_PIXELS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(H_PIXELS - 1);

  fetch_state_t     state_q, state_d;
  logic [CNT_W-1:0] fetch_cnt_q;
  logic [FB_AW-1:0] line_addr_q;
  logic             disp_bank_q;
  logic [CNT_W-1:0] valid_cnt_q [2];
  logic             underrun_q;

  // Read pipeline: whether last cycle's read hit fetched data, and from which bank
  logic             rd_hit_q;
  logic             rd_bank_q;

  logic             ack_take;
  logic             last_ack;
  logic             abort_swap;
  logic             start_fetch;
  logic             back_bank;
  logic             new_back;
  logic             rd_in_range;
  rgb565_t          wr_pix;
  rgb565_t          rdata0, rdata1;

  assign back_bank = ~disp_bank_q;
  // Bank that will be "back" after this edge; a same-cycle swap flips it
  assign new_back  = swap ? disp_bank_q : back_bank;
  assign wr_pix    = rgb565_t'(mem_rdata);

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    ack_take    = 1'b0;
    last_ack    = 1'b0;
    abort_swap  = 1'b0;
    start_fetch = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ack_take = 1'b1;
          if (fetch_cnt_q == LAST) begin
            last_ack = 1'b1;
            state_d  = IDLE;
          end
        end
        // A swap racing the final ack loses nothing: the line is complete.
        // Any earlier swap means the display got a partial line.
        if (swap && !last_ack) begin
          abort_swap = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A new line request overrides completion/abort and restarts from column 0
    if (fetch_start) begin
      start_fetch = 1'b1;
      state_d     = FETCH;
    end
  end

  assign mem_addr = mem_req ? (line_addr_q + FB_AW'(fetch_cnt_q)) : '0;
  assign underrun = underrun_q;

  // ---------------------------------------------------------------------------
  // Fetch datapath, bank bookkeeping and read pipeline
  // ---------------------------------------------------------------------------
  assign rd_in_range = ({1'b0, rd_x} < H_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q    <= '0;
      line_addr_q    <= '0;
      disp_bank_q    <= 1'b0;
      valid_cnt_q[0] <= '0;
      valid_cnt_q[1] <= '0;
      underrun_q     <= 1'b0;
      rd_hit_q       <= 1'b0;
      rd_bank_q      <= 1'b0;
    end else begin
      // The accepted word always lands in the pre-swap back bank
      if (ack_take) begin
        fetch_cnt_q            <= fetch_cnt_q + 1'b1;
        valid_cnt_q[back_bank] <= valid_cnt_q[back_bank] + 1'b1;
      end
      if (abort_swap) begin
        underrun_q <= 1'b1;
      end
      if (swap) begin
        disp_bank_q <= ~disp_bank_q;
      end
      // Placed last so restart clears win over the same-cycle increments above
      if (start_fetch) begin
        line_addr_q           <= FB_BASE + line_offset(fetch_y, H_PIXELS);
        fetch_cnt_q           <= '0;
        valid_cnt_q[new_back] <= '0;
      end
      // Reads always see the pre-swap display bank and its current fill level
      rd_hit_q  <= rd_en && rd_in_range && ({1'b0, rd_x} < valid_cnt_q[disp_bank_q]);
      rd_bank_q <= disp_bank_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Banks
  // ---------------------------------------------------------------------------
  line_ram #(
    .DEPTH (H_PIXELS),
    .AW    (X_W)
  ) u_bank0 (
    .clk   (clk),
    .we    (ack_take && (back_bank == 1'b0)),
    .waddr (fetch_cnt_q[X_W-1:0]),
    .wdata (wr_pix),
    .re    (rd_en && rd_in_range && (disp_bank_q == 1'b0)),
    .raddr (rd_x),
    .rdata (rdata0)
  );

  line_ram #(
    .DEPTH (H_PIXELS),
    .AW    (X_W)
  ) u_bank1 (
    .clk   (clk),
    .we    (ack_take && (back_bank == 1'b1)),
    .waddr (fetch_cnt_q[X_W-1:0]),
    .wdata (wr_pix),
    .re    (rd_en && rd_in_range && (disp_bank_q == 1'b1)),
    .raddr (rd_x),
    .rdata (rdata1)
  );

  // Both RAM outputs and the hit/bank flags are flops, so pix_rgb is a
  // registered value behind a small mux; a miss or idle cycle forces zero.
  assign pix_rgb = rd_hit_q ? (rd_bank_q ? PIX_W'(rdata1) : PIX_W'(rdata0)) : '0;

endmodule

// File: tb/tb_scanline_buffer.sv
module tb_scanline_buffer;

  localparam int          H    = 640;
  localparam logic [18:0] BASE = 19'h00000;
  localparam int          WRAP = 524288;

  logic        clk = 1'b0;
  logic        rst, fetch_start, swap, rd_en, mem_ack;
  logic [8:0]  fetch_y;
  logic [9:0]  rd_x;
  logic [15:0] mem_rdata, pix_rgb;
  logic        mem_req, underrun;
  logic [18:0] mem_addr;

  always #5 clk = ~clk;

  scanline_buffer #(
    .H_PIXELS (H),
    .FB_BASE  (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .fetch_y     (fetch_y),
    .swap        (swap),
    .rd_en       (rd_en),
    .rd_x        (rd_x),
    .pix_rgb     (pix_rgb),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .underrun    (underrun)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: two line arrays with fill levels, which one is shown,
  // and the line currently being filled.
  logic [15:0] m_bank [2][H];
  int          m_valid [2];
  int          m_disp;
  bit          m_fetching;
  int          m_cnt;
  int          m_base;
  bit          m_underrun;

  logic [15:0] exp_q [$];
  bit          mon_en = 1'b0;

  int          ack_mode;     // 0: every cycle, 1: every third cycle, 2: random
  bit          data_random;
  int          cyc = 0;
  int          dut_acks = 0;
  logic [18:0] ack_addr_seen = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int m_addr();
    return (m_base + m_cnt) % WRAP;
  endfunction

  function automatic bit ack_pick();
    case (ack_mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return bit'($urandom_range(0, 1));
    endcase
  endfunction

  // Apply the inputs just sampled by the clock edge to the model.
  task automatic model_update();
    int back;
    if (rst) begin
      m_fetching = 1'b0;
      m_cnt      = 0;
      m_valid[0] = 0;
      m_valid[1] = 0;
      m_disp     = 0;
      m_underrun = 1'b0;
      exp_q.push_back(16'h0000);
      mon_en     = 1'b1;
    end else begin
      back = 1 - m_disp;
      if (rd_en && (int'(rd_x) < H) && (int'(rd_x) < m_valid[m_disp]))
        exp_q.push_back(m_bank[m_disp][rd_x]);
      else
        exp_q.push_back(16'h0000);
      if (m_fetching && mem_ack) begin
        m_bank[back][m_cnt] = mem_rdata;
        m_valid[back]++;
        m_cnt++;
        if (m_cnt == H) m_fetching = 1'b0;
      end
      if (swap) begin
        if (m_fetching) begin
          m_underrun = 1'b1;
          m_fetching = 1'b0;
        end
        m_disp = back;
      end
      if (fetch_start) begin
        m_fetching     = 1'b1;
        m_cnt          = 0;
        m_base         = (int'(BASE) + int'(fetch_y) * H) % WRAP;
        m_valid[1 - m_disp] = 0;
      end
    end
  endtask

  // One clock: observe handshake, advance, update model, drive next inputs.
  task automatic step();
    if (mem_ack && mem_req) begin
      ack_addr_seen = mem_addr;
      dut_acks++;
    end
    @(posedge clk);
    #1;
    model_update();
    cyc++;
    rst         = 1'b0;
    fetch_start = 1'b0;
    swap        = 1'b0;
    rd_en       = 1'b0;
    mem_ack     = m_fetching && ack_pick();
    mem_rdata   = data_random ? 16'($urandom) : 16'(m_addr());
  endtask

  task automatic run_fetch(input string name, input int max_cycles);
    int n;
    n = 0;
    while (m_fetching && n < max_cycles) begin
      step();
      n++;
    end
    check(name, {31'd0, mem_req}, 32'd0);
  endtask

  task automatic run_to_count(input int target, input int max_cycles);
    int n;
    n = 0;
    while (m_fetching && m_cnt < target && n < max_cycles) begin
      step();
      n++;
    end
    check("reach_count", m_cnt, target);
  endtask

  task automatic read_line();
    for (int x = 0; x < H; x++) begin
      rd_en = 1'b1;
      rd_x  = 10'(x);
      step();
    end
  endtask

  // Monitor: pops one expected pixel per cycle and checks the fetch side.
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pix_rgb", pix_rgb, e);
      end
      check("mem_req", {31'd0, mem_req}, {31'd0, m_fetching});
      if (m_fetching) check("mem_addr", mem_addr, m_addr());
      check("underrun", {31'd0, underrun}, {31'd0, m_underrun});
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; fetch_start = 1'b0; fetch_y = '0; swap = 1'b0;
    rd_en = 1'b0; rd_x = '0; mem_ack = 1'b0; mem_rdata = '0;
    ack_mode = 0; data_random = 1'b0;

    // Reset state
    step();
    rst = 1'b1;
    step();
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_pix", pix_rgb, 0);
    check("rst_underrun", {31'd0, underrun}, 0);

    // Line 0, ack every cycle, data = address
    dut_acks = 0;
    fetch_y = 9'd0; fetch_start = 1'b1;
    step();
    check("line0_first_addr", mem_addr, 0);
    run_fetch("line0_done", 3000);
    check("line0_acks", dut_acks, 640);
    check("line0_last_addr", ack_addr_seen, 639);
    step();
    swap = 1'b1;
    step();
    rd_en = 1'b1; rd_x = 10'd5;
    step();
    check("line0_x5", pix_rgb, 16'h0005);
    read_line();
    rd_en = 1'b1; rd_x = 10'd640;
    step();
    check("x640_zero", pix_rgb, 0);

    // Last visible line address range
    data_random = 1'b1;
    fetch_y = 9'd479; fetch_start = 1'b1;
    step();
    check("y479_first", mem_addr, 306560);
    run_fetch("y479_done", 3000);
    check("y479_last", ack_addr_seen, 307199);

    // Slow memory, swap after 100 words -> underrun, partial line
    ack_mode = 1;
    fetch_y = 9'd7; fetch_start = 1'b1;
    step();
    run_to_count(100, 1000);
    mem_ack = 1'b0;
    swap = 1'b1;
    step();
    check("partial_underrun", {31'd0, underrun}, 1);
    rd_en = 1'b1; rd_x = 10'd99;
    step();
    check("partial_x99", pix_rgb, m_bank[m_disp][99]);
    rd_en = 1'b1; rd_x = 10'd100;
    step();
    check("partial_x100", pix_rgb, 0);

    // Swap coincident with the final ack -> no underrun, full line shown
    rst = 1'b1;
    step();
    ack_mode = 0;
    fetch_y = 9'd3; fetch_start = 1'b1;
    step();
    run_to_count(H - 1, 2000);
    check("final_ack_pending", {31'd0, mem_ack}, 1);
    swap = 1'b1;
    step();
    check("final_swap_underrun", {31'd0, underrun}, 0);
    check("final_swap_req", {31'd0, mem_req}, 0);
    read_line();
    rd_en = 1'b1; rd_x = 10'd639;
    step();
    check("final_x639", pix_rgb, m_bank[m_disp][639]);

    // Restart mid-fetch
    fetch_y = 9'd10; fetch_start = 1'b1;
    step();
    run_to_count(50, 500);
    fetch_y = 9'd20; fetch_start = 1'b1;
    step();
    check("restart_addr", mem_addr, 12800);
    step();
    check("restart_next", mem_addr, 12801);
    check("restart_no_underrun", {31'd0, underrun}, 0);

    // Set underrun, then reset mid-fetch with ack high
    swap = 1'b1;
    step();
    check("abort_underrun", {31'd0, underrun}, 1);
    fetch_y = 9'd30; fetch_start = 1'b1;
    step();
    step();
    step();
    rst = 1'b1; mem_ack = 1'b1; rd_en = 1'b1; rd_x = 10'd3;
    step();
    check("rst_mid_req", {31'd0, mem_req}, 0);
    check("rst_mid_pix", pix_rgb, 0);
    check("rst_mid_underrun", {31'd0, underrun}, 0);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    check("stray_ack_req", {31'd0, mem_req}, 0);
    check("stray_ack_addr", mem_addr, 0);
    rd_en = 1'b1; rd_x = 10'd700;
    step();
    check("x700_zero", pix_rgb, 0);

    // Random complete lines with random reads
    ack_mode = 2;
    for (int l = 0; l < 4; l++) begin
      fetch_y = 9'($urandom_range(0, 511)); fetch_start = 1'b1;
      step();
      run_fetch("rand_line_done", 4000);
      swap = 1'b1;
      step();
      for (int k = 0; k < 200; k++) begin
        rd_en = 1'($urandom_range(0, 3) != 0);
        rd_x  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                             : 10'($urandom_range(0, H - 1));
        step();
      end
    end

    // Fully random interleaving of fetch, swap and reads
    for (int k = 0; k < 6000; k++) begin
      fetch_start = ($urandom_range(0, 999) == 0);
      fetch_y     = 9'($urandom_range(0, 511));
      swap        = ($urandom_range(0, 1499) == 0);
      rd_en       = 1'($urandom_range(0, 1));
      rd_x        = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                                 : 10'($urandom_range(0, H - 1));
      step();
    end

    step();
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scanline_buffer.md
SCANLINE_BUFFER -- requirements
Module: scanline_buffer

Interface
REQ-001 Parameter H_PIXELS, default 640, pixels per visible line and per bank.
REQ-002 Parameter FB_BASE, default 19'h00000, framebuffer word address of pixel (0,0).
REQ-003 clk  in  1  single system clock, 100 MHz; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 fetch_start  in  1  one-cycle pulse: begin fetching line fetch_y into back bank.
REQ-006 fetch_y  in  9  line number to fetch, sampled on fetch_start.
REQ-007 swap  in  1  one-cycle pulse at start of each visible line: back bank becomes display bank.
REQ-008 rd_en  in  1  display read strobe.
REQ-009 rd_x  in  10  display pixel column, sampled with rd_en.
REQ-010 pix_rgb  out  16  RGB565 pixel, {r[4:0],g[5:0],b[4:0]}, registered.
REQ-011 mem_req  out  1  framebuffer read request, held until acknowledged.
REQ-012 mem_addr  out  19  framebuffer word address, stable while mem_req high.
REQ-013 mem_ack  in  1  request accepted; mem_rdata valid this cycle.
REQ-014 mem_rdata  in  16  RGB565 pixel word.
REQ-015 underrun  out  1  sticky flag: swap occurred before back-bank fetch completed.

Function
REQ-016 Two banks of H_PIXELS x 16 bits; disp_bank selects display bank; back bank = ~disp_bank.
REQ-017 FSM states IDLE, FETCH; IDLE->FETCH on fetch_start; FETCH->IDLE on mem_ack with fetch_cnt == H_PIXELS-1.
REQ-018 On fetch_start: line_addr = FB_BASE + fetch_y*H_PIXELS, computed with shifts/adds (y<<9 + y<<7 for 640), 19-bit wrap; fetch_cnt and back-bank valid count cleared.
REQ-019 In FETCH: mem_req=1, mem_addr=line_addr+fetch_cnt; on mem_ack, mem_rdata written to back bank at fetch_cnt, fetch_cnt and valid count increment same cycle.
REQ-020 mem_req deasserts the cycle after final mem_ack; at most one outstanding request; mem_addr never changes while mem_req high without mem_ack.
REQ-021 fetch_start during FETCH aborts current fetch and restarts with new fetch_y next cycle; underrun unaffected.
REQ-022 On swap: disp_bank toggles; if FSM in FETCH (or in final-ack cycle without completion), underrun<=1 and fetch aborted to IDLE.
REQ-023 swap coincident with final mem_ack: write completes into old back bank before toggle; no underrun.
REQ-024 Each bank keeps valid count (0..H_PIXELS); bank entries at x >= valid count read as 16'h0000.
REQ-025 Read latency 1 cycle: rd_en at cycle N -> pix_rgb at N+1 = display bank[rd_x] (or 0 per REQ-024); rd_x >= H_PIXELS -> 0.
REQ-026 rd_en low: pix_rgb <= 16'h0000 (blanking-safe output).
REQ-027 swap and rd_en same cycle: read uses pre-swap display bank.
REQ-028 fetch_start and swap same cycle: swap processed (including underrun check on old fetch), then new fetch starts into new back bank.

Reset
REQ-029 On rst: state IDLE, mem_req 0, mem_addr 0, pix_rgb 0, underrun 0, disp_bank 0, fetch_cnt 0, both valid counts 0.
REQ-030 rst mid-fetch: request dropped same edge; a pending mem_ack after reset ignored; bank RAM contents not cleared.

Structure
REQ-031 Shared package krypton_pkg holds H_PIXELS/V timing constants, rgb565_t typedef, FB address width constant.
REQ-032 One sub-module line_ram (simple dual-port, 1 write/1 registered read, H_PIXELS x 16) instantiated twice for the banks.

Verification
REQ-033 Reset, fetch_start y=0, mem_ack every cycle, rdata=addr[15:0] -> 640 requests addr 0..639, mem_req low after; after swap rd_x=5 -> pix_rgb=16'h0005 next cycle.
REQ-034 fetch_y=479, FB_BASE=0 -> first mem_addr=306560, last 307199.
REQ-035 mem_ack every 3rd cycle, swap after 100 acks -> underrun=1, rd_x=99 gives rdata word, rd_x=100 gives 16'h0000.
REQ-036 swap same cycle as 640th mem_ack -> underrun stays 0; full line readable.
REQ-037 fetch_start y=10 then fetch_start y=20 after 50 acks -> next mem_addr=FB_BASE+12800, fetch_cnt restarts at 0.
REQ-038 rst asserted mid-fetch with mem_ack high -> mem_req=0, pix_rgb=0, underrun=0 next cycle; rd_en with rd_x=700 -> 16'h0000.
